// File: rtl/imm_gen_pkg.sv
// Shared definitions for the immediate generator stage: format codes,
// RISC-V major opcodes, the per-instruction result record and skid states.
package imm_gen_pkg;

    localparam int XLEN_MAX = 64;

    // Format / select encoding (shared by in_sel and out_fmt)
    localparam logic [2:0] FMT_I    = 3'b000;
    localparam logic [2:0] FMT_S    = 3'b001;
    localparam logic [2:0] FMT_B    = 3'b010;
    localparam logic [2:0] FMT_U    = 3'b011;
    localparam logic [2:0] FMT_J    = 3'b100;
    localparam logic [2:0] FMT_NONE = 3'b101;
    localparam logic [2:0] SEL_AUTO = 3'b111;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    // One decoded instruction; imm is sign-extended to XLEN, zero above XLEN
    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        logic [2:0]          fmt;
        logic                illegal;
    } imm_result_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// Combinational immediate extraction: resolves the format (explicit select
// or opcode auto-decode) and builds the sign-extended immediate.
module imm_extract
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]  instr,
    input  logic [2:0]   sel,
    output imm_result_t  result
);

    logic [2:0]      fmt_s;
    logic            illegal_s;
    logic [31:0]     imm32_s;
    logic [XLEN-1:0] imm_x_s;

    // Resolve the effective format and the illegal flag
    always_comb begin
        fmt_s     = FMT_NONE;
        illegal_s = 1'b0;
        if (sel == SEL_AUTO) begin
            case (instr[6:0])
                OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_IMM32: fmt_s = FMT_I;
                OP_STORE:         fmt_s = FMT_S;
                OP_BRANCH:        fmt_s = FMT_B;
                OP_LUI, OP_AUIPC: fmt_s = FMT_U;
                OP_JAL:           fmt_s = FMT_J;
                OP_OP, OP_OP32: begin
                    fmt_s     = FMT_NONE;
                    illegal_s = 1'b0;
                end
                default: begin
                    fmt_s     = FMT_NONE;
                    illegal_s = 1'b1;
                end
            endcase
        end else begin
            case (sel)
                FMT_I, FMT_S, FMT_B, FMT_U, FMT_J: fmt_s = sel;
                default: begin
                    fmt_s     = FMT_NONE;
                    illegal_s = 1'b1;
                end
            endcase
        end
    end

    // Assemble the immediate, sign-extended to 32 bits from instr[31]
    always_comb begin
        imm32_s = 32'd0;
        case (fmt_s)
            FMT_I:   imm32_s = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32_s = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32_s = {instr[31:12], 12'd0};
            FMT_J:   imm32_s = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32_s = 32'd0;
        endcase
    end

    // Widen to XLEN (bit 31 replicated) and pack the result record
    always_comb begin
        imm_x_s        = XLEN'($signed(imm32_s));
        result.imm     = XLEN_MAX'(imm_x_s);
        result.fmt     = fmt_s;
        result.illegal = illegal_s;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered valid/ready immediate-generator stage with a 2-entry skid
// buffer. Extraction lives in imm_extract; this level only buffers.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    imm_result_t new_res_s;
    imm_result_t head_r;
    imm_result_t tail_r;
    skid_state_e state_r;
    skid_state_e state_nxt_s;
    logic        in_ready_r;
    logic        out_valid_r;
    logic        in_xfer_s;
    logic        out_xfer_s;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr  (in_instr),
        .sel    (in_sel),
        .result (new_res_s)
    );

    // Bits of the record above XLEN are always zero and never leave the stage
    if (XLEN < XLEN_MAX) begin : g_unused_hi
        logic unused_hi_s;
        assign unused_hi_s = |{head_r.imm[XLEN_MAX-1:XLEN], 1'b0};
    end

    // Handshake qualifiers
    always_comb begin
        in_xfer_s  = in_valid & in_ready;
        out_xfer_s = out_valid_r & out_ready;
    end

    // Occupancy state and its registered decodes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= SKID_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != SKID_TWO);
            out_valid_r <= (state_nxt_s != SKID_EMPTY);
        end
    end

    // Next occupancy from the two transfer strobes
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            SKID_EMPTY: begin
                if (in_xfer_s) state_nxt_s = SKID_ONE;
                else           state_nxt_s = SKID_EMPTY;
            end
            SKID_ONE: begin
                if (in_xfer_s && !out_xfer_s)      state_nxt_s = SKID_TWO;
                else if (!in_xfer_s && out_xfer_s) state_nxt_s = SKID_EMPTY;
                else                               state_nxt_s = SKID_ONE;
            end
            SKID_TWO: begin
                if (out_xfer_s) state_nxt_s = SKID_ONE;
                else            state_nxt_s = SKID_TWO;
            end
            default: state_nxt_s = SKID_EMPTY;
        endcase
    end

    // Entry storage: head feeds the outputs, tail catches a stalled arrival
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r <= '0;
            tail_r <= '0;
        end else begin
            case (state_r)
                SKID_EMPTY: if (in_xfer_s) head_r <= new_res_s;
                SKID_ONE: begin
                    if (in_xfer_s && out_xfer_s) head_r <= new_res_s;
                    else if (in_xfer_s)          tail_r <= new_res_s;
                end
                SKID_TWO: if (out_xfer_s) head_r <= tail_r;
                default: head_r <= head_r;
            endcase
        end
    end

    // Port drive; single-register mode derives in_ready from the consumer
    always_comb begin
        out_valid   = out_valid_r;
        out_imm     = head_r.imm[XLEN-1:0];
        out_fmt     = head_r.fmt;
        out_illegal = head_r.illegal;
        if (SKID_EN) in_ready = in_ready_r;
        else         in_ready = out_ready | ~out_valid_r;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Next-generation immediate generator for the RISC-V datapath: extracts and sign-extends the immediate for I, S, B, U and J formats.
- XLEN is parametrised (32/64).
- An auto-decode mode derives the format from the opcode instead of an explicit select.
- Sits between fetch and execute as a registered, valid/ready-handshaked stage with a 2-entry skid buffer, so downstream stalls never drop an instruction.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64.
SKID_EN, 1, 1 = 2-entry skid buffer (full throughput under backpressure); 0 = single register (in_ready = out_ready | ~out_valid).

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction present
in_ready  output  1  stage can accept
in_instr  input  32  raw instruction word
in_sel  input  3  000 I, 001 S, 010 B, 011 U, 100 J, 111 auto; 101/110 reserved
out_valid  output  1  result present
out_ready  input  1  downstream accepts
out_imm  output  XLEN  sign-extended immediate
out_fmt  output  3  resolved format, same encoding as in_sel; 101 = R/none
out_illegal  output  1  reserved sel, or auto with unrecognised opcode

Behaviour:
- Reset: async assert clears both entries. out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, in_ready=1 (combinational from cleared state). Deassertion takes effect synchronously at the next clk edge.
- Transfers: an input transfer occurs on in_valid&in_ready; an output transfer occurs on out_valid&out_ready. Latency is exactly 1 cycle from input transfer to out_valid.
- Ordering: strict FIFO order. No reordering, duplication or loss.
- Output stability: while out_valid=1 and out_ready=0, out_imm, out_fmt and out_illegal hold stable.
- Skid states: EMPTY, ONE, TWO.
  - EMPTY→ONE on input transfer.
  - ONE→TWO on input without output.
  - ONE→EMPTY on output without input.
  - ONE→ONE on simultaneous input and output.
  - TWO→ONE on output.
- in_ready: 0 only in TWO. It is a registered state decode, so there is no combinational path from out_ready.
- Simultaneous input and output in ONE: the head is replaced by the new result in the same edge.
- Immediate extraction (combinational, before the register):
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - All formats sign-extend from instr[31] to XLEN. U sign-extends bit 31 when XLEN=64.
- Auto decode on opcode instr[6:0]:
  - 0010011, 0000011, 1100111, 1110011, 0011011 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - 0110011, 0111011 → fmt 101, imm 0, illegal 0
  - anything else → fmt 101, imm 0, illegal 1
- Reserved sel (101/110): imm 0, fmt 101, illegal 1. Still handshaked like any other result; never drops or stalls.
- Reset mid-operation: all buffered entries are discarded, and no stale out_valid appears after reset release.

Decomposition:
- Package imm_gen_pkg:
  - format codes FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE, SEL_AUTO;
  - opcode constants;
  - result typedef {imm, fmt, illegal}.
- Sub-module imm_extract: purely combinational; parametrised by XLEN; takes instr and sel; returns a result struct.
- The top level owns only the skid/handshake logic.

Test Plan:
- I, S, B formats (XLEN=32), each presented for one cycle with out_ready=1:
  - sel=000, instr=0xFFF00000 → out_imm=0xFFFFFFFF, fmt=000, one cycle later.
  - sel=001, instr=0xFE000F80 → 0xFFFFFFFF, fmt=001.
  - sel=010, instr=0x7E000F80 → 0x00000FFE, fmt=010.
- Auto decode:
  - instr=0x12345037 (LUI) → 0x12345000, fmt=011.
  - instr=0x800000EF (JAL) → 0xFFF00000, fmt=100.
  - instr=0x00000033 → imm 0, fmt=101, illegal=0.
  - instr=0x0000007F → imm 0, fmt=101, illegal=1.
- XLEN=64: sel=000, instr=0xFFF00000 → 0xFFFFFFFFFFFFFFFF; sel=011, instr=0x80000037 → 0xFFFFFFFF80000000.
- Backpressure (SKID_EN=1):
  - Hold out_ready=0 and stream three instructions: in_ready drops after two accepted, and out_imm holds the first result.
  - Raise out_ready: the three results emerge in order on consecutive cycles.
- Full throughput: out_ready=1 with in_valid continuously high for 16 instructions → 16 results on 16 consecutive cycles, no bubbles.
- Reset mid-operation: drop rst_n asynchronously with two entries buffered → out_valid=0 immediately; after release, in_ready=1 and no old results appear.
